// File: rtl/kd_tree_pkg.sv
// Shared kd-tree encodings: root/node command codes, data field offsets and root FSM states.
// The ERR state exists only when KD_ROOT_TIMEOUT_EN is defined.
package kd_tree_pkg;

   localparam int unsigned KD_CMD_W     = 3;
   localparam int unsigned KD_DEPTH_LSB = 0;
   localparam int unsigned KD_DEPTH_W   = 8;
   localparam int unsigned KD_AXIS_LSB  = 8;
   localparam int unsigned KD_AXIS_W    = 2;
   localparam int unsigned KD_CFG_W     = KD_AXIS_LSB + KD_AXIS_W;

   typedef enum logic [KD_CMD_W-1:0] {
      CMD_NOP        = 3'd0,
      CMD_CFG_DEPTH  = 3'd1,
      CMD_SORT_ACK   = 3'd2,
      CMD_START_SORT = 3'd3,
      CMD_SORT_DONE  = 3'd4
   } kdCmdE;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_WAIT_ACK,
      ST_START,
      ST_SORTING,
      ST_STOP
`ifdef KD_ROOT_TIMEOUT_EN
      , ST_ERR
`endif
   } kdRootStateE;

   // Places depth and axis in their CFG_DEPTH data fields, all other bits zero.
   function automatic logic [KD_CFG_W-1:0] kdPackCfg(input logic [KD_DEPTH_W-1:0] depth,
                                                     input logic [KD_AXIS_W-1:0]  axis);
      logic [KD_CFG_W-1:0] packed_v;
      packed_v = '0;
      packed_v[KD_DEPTH_LSB +: KD_DEPTH_W] = depth;
      packed_v[KD_AXIS_LSB +: KD_AXIS_W]   = axis;
      return packed_v;
   endfunction

endpackage

// File: rtl/kd_watchdog.sv
// Cycle watchdog for the kd-tree root controller, instantiated only under KD_ROOT_TIMEOUT_EN.
// Accumulates cycles while run is high, holds otherwise; rst clears the count.
module kd_watchdog #(
   parameter int unsigned TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (run && (count_q != CNT_W'(TIMEOUT))) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Fires during the TIMEOUT-th run cycle so the owner can leave on that edge.
   assign expired = run && (count_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/kd_root_ctrl.sv
// Root controller of the kd-tree sorter: configures the root, starts the sort and waits for stability.
// Define KD_ROOT_TIMEOUT_EN to add the kd_watchdog timeout path (ERR state, error pulse).
module kd_root_ctrl
   import kd_tree_pkg::*;
#(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned CMD_W         = 3,
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned TIMEOUT       = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        cfg_depth,
   input  logic [1:0]        cfg_axis,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CMD_W-1:0]  cmd_to_root,
   output logic [DATA_W-1:0] data_to_root,
   output logic              alert_to_root,
   input  logic [CMD_W-1:0]  cmd_from_root,
   input  logic              alert_from_root,
   input  logic              stable_from_root
);

   localparam int unsigned STABLE_CNT_W =
      (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
   localparam logic [STABLE_CNT_W-1:0] STABLE_MAX = STABLE_CNT_W'(STABLE_CYCLES);

   kdRootStateE             state_q, state_d;
   logic [STABLE_CNT_W-1:0] stableCnt_q, stableCnt_d;
   logic [7:0]              depth_q;
   logic [1:0]              axis_q;

   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    alert_q, alert_d;
   logic [CMD_W-1:0]        cmd_q, cmd_d;
   logic [DATA_W-1:0]       data_q, data_d;

   logic                    ackSeen;
   logic                    wdExpired;

   assign ackSeen = alert_from_root && (cmd_from_root == CMD_W'(CMD_SORT_ACK));

`ifdef KD_ROOT_TIMEOUT_EN
   logic error_q, error_d;
   logic wdRun;
   logic wdClear;

   // The budget spans WAIT_ACK and SORTING together, so it is only cleared back in IDLE.
   assign wdRun   = (state_q == ST_WAIT_ACK) || (state_q == ST_SORTING);
   assign wdClear = rst || (state_q == ST_IDLE);

   kd_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (wdClear),
      .run     (wdRun),
      .expired (wdExpired)
   );

   assign error = error_q;
`else
   assign wdExpired = 1'b0;
   assign error     = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         stableCnt_q <= '0;
         depth_q     <= '0;
         axis_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         alert_q     <= 1'b0;
         cmd_q       <= CMD_W'(CMD_NOP);
         data_q      <= '0;
`ifdef KD_ROOT_TIMEOUT_EN
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         stableCnt_q <= stableCnt_d;
         if ((state_q == ST_IDLE) && start) begin
            depth_q <= cfg_depth;
            axis_q  <= cfg_axis;
         end
         busy_q      <= busy_d;
         done_q      <= done_d;
         alert_q     <= alert_d;
         cmd_q       <= cmd_d;
         data_q      <= data_d;
`ifdef KD_ROOT_TIMEOUT_EN
         error_q     <= error_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      stableCnt_d = '0;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_CFG;
         ST_CFG:      state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: if (ackSeen) state_d = ST_START;
         ST_START:    state_d = ST_SORTING;
         ST_SORTING: begin
            // Any unstable cycle restarts the run of stable cycles from zero.
            if (stable_from_root) begin
               stableCnt_d = (stableCnt_q == STABLE_MAX) ? stableCnt_q : stableCnt_q + 1'b1;
            end
            if (stableCnt_d == STABLE_MAX) state_d = ST_STOP;
         end
         ST_STOP:     state_d = ST_IDLE;
`ifdef KD_ROOT_TIMEOUT_EN
         ST_ERR:      state_d = ST_IDLE;
`endif
         default:     state_d = ST_IDLE;
      endcase
`ifdef KD_ROOT_TIMEOUT_EN
      if (wdExpired) state_d = ST_ERR;
`endif
   end

   // Outputs are decoded from the current state and registered, adding one cycle of latency.
   always_comb begin
      busy_d  = (state_q != ST_IDLE);
      done_d  = 1'b0;
      alert_d = 1'b0;
      cmd_d   = CMD_W'(CMD_NOP);
      data_d  = '0;
`ifdef KD_ROOT_TIMEOUT_EN
      error_d = 1'b0;
`endif
      case (state_q)
         ST_CFG: begin
            alert_d                = 1'b1;
            cmd_d                  = CMD_W'(CMD_CFG_DEPTH);
            data_d[KD_CFG_W-1:0]   = kdPackCfg(depth_q, axis_q);
         end
         ST_START: begin
            alert_d = 1'b1;
            cmd_d   = CMD_W'(CMD_START_SORT);
         end
         ST_STOP: begin
            alert_d = 1'b1;
            cmd_d   = CMD_W'(CMD_SORT_DONE);
            done_d  = 1'b1;
         end
`ifdef KD_ROOT_TIMEOUT_EN
         ST_ERR: begin
            error_d = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign alert_to_root = alert_q;
   assign cmd_to_root   = cmd_q;
   assign data_to_root  = data_q;

   logic unusedWd;
   assign unusedWd = wdExpired & 1'b0;

endmodule

// File: tb/tb_kd_root_ctrl.sv
// Scoreboard bench for kd_root_ctrl: commands expected on the root port are queued as stimulus is driven.
// The watchdog scenario is compiled only when KD_ROOT_TIMEOUT_EN is defined.
module tb_kd_root_ctrl;

   localparam int unsigned DATA_W        = 32;
   localparam int unsigned CMD_W         = 3;
   localparam int unsigned STABLE_CYCLES = 4;
   localparam int unsigned TIMEOUT       = 16;

   localparam logic [CMD_W-1:0] C_NOP   = 3'd0;
   localparam logic [CMD_W-1:0] C_CFG   = 3'd1;
   localparam logic [CMD_W-1:0] C_ACK   = 3'd2;
   localparam logic [CMD_W-1:0] C_START = 3'd3;
   localparam logic [CMD_W-1:0] C_DONE  = 3'd4;

   typedef struct {
      logic [CMD_W-1:0]  cmd;
      logic [DATA_W-1:0] data;
      bit                chkData;
      string             tag;
   } expT;

   expT expQ[$];
   expT monE;
   int  vectors     = 0;
   int  miscompares = 0;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [7:0]        cfg_depth = '0;
   logic [1:0]        cfg_axis = '0;
   logic              busy, done, error, alert_to_root;
   logic [CMD_W-1:0]  cmd_to_root;
   logic [DATA_W-1:0] data_to_root;
   logic [CMD_W-1:0]  cmd_from_root = '0;
   logic              alert_from_root = 1'b0;
   logic              stable_from_root = 1'b0;

   kd_root_ctrl #(
      .DATA_W        (DATA_W),
      .CMD_W         (CMD_W),
      .STABLE_CYCLES (STABLE_CYCLES),
      .TIMEOUT       (TIMEOUT)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .cfg_depth        (cfg_depth),
      .cfg_axis         (cfg_axis),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .cmd_to_root      (cmd_to_root),
      .data_to_root     (data_to_root),
      .alert_to_root    (alert_to_root),
      .cmd_from_root    (cmd_from_root),
      .alert_from_root  (alert_from_root),
      .stable_from_root (stable_from_root)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input logic [CMD_W-1:0] c, input logic [DATA_W-1:0] d,
                          input bit chk, input string tag);
      expT e;
      e.cmd = c; e.data = d; e.chkData = chk; e.tag = tag;
      expQ.push_back(e);
   endtask

   // Every qualified command must match the oldest queued expectation; otherwise the bus idles at NOP/0.
   always @(posedge clk) begin
      #1;
      vectors++;
      if (alert_to_root === 1'b1) begin
         if (expQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL sb_unexpected: got cmd=%0d data=0x%0h, expected no command",
                     cmd_to_root, data_to_root);
         end else begin
            monE = expQ.pop_front();
            if (cmd_to_root !== monE.cmd || (monE.chkData && data_to_root !== monE.data)) begin
               miscompares++;
               $display("[TB] FAIL sb_%s: got cmd=%0d data=0x%0h, expected cmd=%0d data=0x%0h",
                        monE.tag, cmd_to_root, data_to_root, monE.cmd, monE.data);
            end
         end
      end else if (cmd_to_root !== C_NOP || data_to_root !== '0 || alert_to_root !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL sb_idle_bus: got alert=%b cmd=%0d data=0x%0h, expected 0/NOP/0",
                  alert_to_root, cmd_to_root, data_to_root);
      end
   end

   // Drives start through CFG, ack and START; returns with START_SORT visible and the FSM in SORTING.
   task automatic goSorting(input logic [7:0] d, input logic [1:0] a);
      start = 1'b1; cfg_depth = d; cfg_axis = a;
      pushExp(C_CFG, DATA_W'({a, d}), 1'b1, "cfg");
      tick();
      start = 1'b0;
      tick();
      alert_from_root = 1'b1; cmd_from_root = C_ACK;
      pushExp(C_START, '0, 1'b1, "start");
      tick();
      alert_from_root = 1'b0; cmd_from_root = C_NOP;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      vectors++;
      if ({busy, done, error, alert_to_root} !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_flags: got busy/done/error/alert=%b, expected 0000",
                  {busy, done, error, alert_to_root});
      end
      vectors++;
      if (cmd_to_root !== C_NOP || data_to_root !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_bus: got cmd=%0d data=0x%0h, expected NOP/0", cmd_to_root, data_to_root);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_sequence();
      start = 1'b1; cfg_depth = 8'd3; cfg_axis = 2'd1;
      pushExp(C_CFG, 32'h103, 1'b1, "basic_cfg");
      tick();
      start = 1'b0; cfg_depth = 8'd0; cfg_axis = 2'd0;
      vectors++;
      if (alert_to_root !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_latency: got alert=%b busy=%b, expected 0 0", alert_to_root, busy);
      end
      tick();
      vectors++;
      if (alert_to_root !== 1'b1 || cmd_to_root !== C_CFG || data_to_root !== 32'h103 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_cfg: got alert=%b cmd=%0d data=0x%0h busy=%b, expected 1 1 0x103 1",
                  alert_to_root, cmd_to_root, data_to_root, busy);
      end
      repeat (4) tick();
      alert_from_root = 1'b1; cmd_from_root = C_ACK;
      pushExp(C_START, '0, 1'b1, "basic_start");
      tick();
      alert_from_root = 1'b0; cmd_from_root = C_NOP;
      vectors++;
      if (alert_to_root !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_start_early: got alert=%b, expected 0", alert_to_root);
      end
      tick();
      vectors++;
      if (alert_to_root !== 1'b1 || cmd_to_root !== C_START || data_to_root !== '0) begin
         miscompares++;
         $display("[TB] FAIL basic_start: got alert=%b cmd=%0d data=0x%0h, expected 1 3 0x0",
                  alert_to_root, cmd_to_root, data_to_root);
      end
      stable_from_root = 1'b1;
      pushExp(C_DONE, '0, 1'b0, "basic_done");
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (done !== (i == 4)) begin
            miscompares++;
            $display("[TB] FAIL basic_done_timing: step %0d got done=%b, expected %b", i, done, (i == 4));
         end
      end
      vectors++;
      if (cmd_to_root !== C_DONE || alert_to_root !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL basic_sort_done: got alert=%b cmd=%0d, expected 1 4", alert_to_root, cmd_to_root);
      end
      stable_from_root = 1'b0;
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL basic_idle: got done=%b busy=%b, expected 0 0", done, busy);
      end
   endtask

   task automatic test_wrong_ack();
      start = 1'b1; cfg_depth = 8'd0; cfg_axis = 2'd2;
      pushExp(C_CFG, 32'h200, 1'b1, "zero_depth_cfg");
      tick();
      start = 1'b0;
      tick();
      vectors++;
      if (data_to_root !== 32'h200 || cmd_to_root !== C_CFG) begin
         miscompares++;
         $display("[TB] FAIL zero_depth_cfg: got cmd=%0d data=0x%0h, expected 1 0x200", cmd_to_root, data_to_root);
      end
      alert_from_root = 1'b1; cmd_from_root = C_START;
      start = 1'b1; cfg_depth = 8'hff; cfg_axis = 2'd3;
      tick();
      tick();
      alert_from_root = 1'b0; cmd_from_root = C_ACK;
      tick();
      tick();
      cmd_from_root = C_NOP; start = 1'b0;
      tick();
      vectors++;
      if (alert_to_root !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL wrong_ack_hold: got alert=%b busy=%b, expected 0 1", alert_to_root, busy);
      end
      alert_from_root = 1'b1; cmd_from_root = C_ACK;
      pushExp(C_START, '0, 1'b1, "wrong_ack_start");
      tick();
      alert_from_root = 1'b0; cmd_from_root = C_NOP;
      tick();
      vectors++;
      if (alert_to_root !== 1'b1 || cmd_to_root !== C_START) begin
         miscompares++;
         $display("[TB] FAIL wrong_ack_advance: got alert=%b cmd=%0d, expected 1 3", alert_to_root, cmd_to_root);
      end
      stable_from_root = 1'b1;
      pushExp(C_DONE, '0, 1'b0, "wrong_ack_done");
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (done !== (i == 4)) begin
            miscompares++;
            $display("[TB] FAIL wrong_ack_done: step %0d got done=%b, expected %b", i, done, (i == 4));
         end
      end
      stable_from_root = 1'b0;
      tick();
   endtask

   task automatic test_stable_pattern();
      bit pat[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      goSorting(8'd5, 2'd3);
      pushExp(C_DONE, '0, 1'b0, "pattern_done");
      for (int i = 0; i < 8; i++) begin
         stable_from_root = pat[i];
         tick();
         vectors++;
         if (done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pattern_early: step %0d got done=%b, expected 0", i, done);
         end
      end
      stable_from_root = 1'b0;
      tick();
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL pattern_done: got done=%b, expected 1", done);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL pattern_pulse: got done=%b, expected 0", done);
      end
   endtask

   task automatic test_reset_mid_sort();
      goSorting(8'd2, 2'd1);
      stable_from_root = 1'b1;
      tick();
      tick();
      rst = 1'b1;
      tick();
      vectors++;
      if ({busy, done, error, alert_to_root} !== 4'b0000 || cmd_to_root !== C_NOP || data_to_root !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: got flags=%b cmd=%0d data=0x%0h, expected 0000 0 0x0",
                  {busy, done, error, alert_to_root}, cmd_to_root, data_to_root);
      end
      rst = 1'b0; stable_from_root = 1'b0;
      tick();
      start = 1'b1; cfg_depth = 8'd7; cfg_axis = 2'd0;
      pushExp(C_CFG, 32'h007, 1'b1, "rearm_cfg");
      tick();
      start = 1'b0;
      tick();
      vectors++;
      if (alert_to_root !== 1'b1 || cmd_to_root !== C_CFG || data_to_root !== 32'h007) begin
         miscompares++;
         $display("[TB] FAIL rearm_cfg: got alert=%b cmd=%0d data=0x%0h, expected 1 1 0x7",
                  alert_to_root, cmd_to_root, data_to_root);
      end
      alert_from_root = 1'b1; cmd_from_root = C_ACK;
      pushExp(C_START, '0, 1'b1, "rearm_start");
      tick();
      alert_from_root = 1'b0; cmd_from_root = C_NOP;
      tick();
      stable_from_root = 1'b1;
      pushExp(C_DONE, '0, 1'b0, "rearm_done");
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (done !== (i == 4)) begin
            miscompares++;
            $display("[TB] FAIL rearm_done: step %0d got done=%b, expected %b", i, done, (i == 4));
         end
      end
      stable_from_root = 1'b0;
      tick();
   endtask

`ifdef KD_ROOT_TIMEOUT_EN
   // 16 cycles in WAIT_ACK, then ERR for one cycle; error is registered, so it shows TIMEOUT+1 ticks in.
   task automatic test_timeout();
      int errAt   = 0;
      bit sawDone = 1'b0;
      start = 1'b1; cfg_depth = 8'd1; cfg_axis = 2'd0;
      pushExp(C_CFG, 32'h001, 1'b1, "timeout_cfg");
      tick();
      start = 1'b0;
      tick();
      for (int n = 1; n <= 40 && errAt == 0; n++) begin
         tick();
         if (done === 1'b1) sawDone = 1'b1;
         if (error === 1'b1) errAt = n;
      end
      vectors++;
      if (errAt != int'(TIMEOUT) + 1) begin
         miscompares++;
         $display("[TB] FAIL timeout_cycle: got error at tick %0d, expected %0d", errAt, TIMEOUT + 1);
      end
      vectors++;
      if (sawDone) begin
         miscompares++;
         $display("[TB] FAIL timeout_no_done: got done=1, expected 0");
      end
      tick();
      vectors++;
      if (error !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL timeout_idle: got error=%b busy=%b done=%b, expected 0 0 0", error, busy, done);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_sequence();
      test_wrong_ack();
      test_stable_pattern();
      test_reset_mid_sort();
`ifdef KD_ROOT_TIMEOUT_EN
      test_timeout();
`endif
      tick();
      vectors++;
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending commands, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "[TB] aborted");
   end

endmodule

// File: doc/kd_root_ctrl.md
KD_ROOT_CTRL -- requirements
Module: kd_root_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the root data channel.
REQ-002 SHALL have parameter CMD_W, default 3, width of the command channel.
REQ-003 SHALL have parameter STABLE_CYCLES, default 4, consecutive stable cycles that end a sort.
REQ-004 SHALL have parameter TIMEOUT, default 1023, watchdog limit in cycles (used only with the macro).
REQ-005 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  in  1  host request, sampled only in IDLE.
REQ-008 SHALL have port cfg_depth  in  8  initial time_to_live sent to the root.
REQ-009 SHALL have port cfg_axis  in  2  initial sorting axis sent to the root.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port done  out  1  one-cycle pulse on sort completion.
REQ-012 SHALL have port error  out  1  one-cycle pulse on watchdog expiry.
REQ-013 SHALL have port cmd_to_root  out  CMD_W  command to the root node's top port.
REQ-014 SHALL have port data_to_root  out  DATA_W  data to the root node's top port.
REQ-015 SHALL have port alert_to_root  out  1  qualifies cmd_to_root/data_to_root for one cycle.
REQ-016 SHALL have port cmd_from_root  in  CMD_W  command returned by the root node.
REQ-017 SHALL have port alert_from_root  in  1  qualifies cmd_from_root.
REQ-018 SHALL have port stable_from_root  in  1  root reports no switch in the current cycle.

Function
REQ-019 SHALL implement FSM states IDLE, CFG, WAIT_ACK, START, SORTING, STOP, plus ERR when the macro is compiled in.
REQ-020 SHALL move IDLE->CFG on start=1 and latch cfg_depth/cfg_axis on that edge.
REQ-021 SHALL, in CFG (one cycle), drive alert_to_root=1, cmd=CFG_DEPTH, data[7:0]=latched depth, data[9:8]=latched axis, all other data bits 0; next state WAIT_ACK.
REQ-022 SHALL stay in WAIT_ACK until alert_from_root=1 with cmd_from_root=SORT_ACK; any other command or an unqualified command SHALL be ignored.
REQ-023 SHALL, in START (one cycle), drive alert_to_root=1, cmd=START_SORT, data=0; next state SORTING.
REQ-024 SHALL, in SORTING, count consecutive cycles with stable_from_root=1, clear the count on any 0, and exit to STOP when the count reaches STABLE_CYCLES.
REQ-025 SHALL, in STOP (one cycle), drive alert_to_root=1, cmd=SORT_DONE, and done=1; next state IDLE.
REQ-026 SHALL drive cmd=NOP, data=0, alert_to_root=0 in every state not named above as issuing a command.
REQ-027 SHALL register all outputs: start at edge t yields the CFG command visible after edge t+1.
REQ-028 SHALL ignore start while busy=1.
REQ-029 SHALL accept cfg_depth=0 (single-node tree) with an unchanged sequence.
REQ-030 SHALL count the stable counter with a saturating counter of width clog2(STABLE_CYCLES+1).

Reset
REQ-031 SHALL on rst=1 force IDLE, clear counters, and drive busy=0, done=0, error=0, alert_to_root=0, cmd=NOP, data=0; rst SHALL take priority over every other event, including mid-sequence.

Configuration
REQ-032 SHALL, with KD_ROOT_TIMEOUT_EN defined, count cycles spent in WAIT_ACK plus SORTING and, on reaching TIMEOUT, enter ERR, which for one cycle drives error=1 and cmd=NOP, then returns to IDLE without pulsing done.
REQ-033 SHALL, without KD_ROOT_TIMEOUT_EN, wait indefinitely and tie error to 0.

Structure
REQ-034 SHALL take the command encodings (NOP=0, CFG_DEPTH=1, SORT_ACK=2, START_SORT=3, SORT_DONE=4) and the data field offsets from shared package kd_tree_pkg, which kd-tree nodes also use.
REQ-035 SHALL place the watchdog in sub-module kd_watchdog (inputs clk, rst, run; output expired).

Verification
REQ-036 SHALL verify this sequence: start with depth=3, axis=1 -> CFG with data=0x103; SORT_ACK after 5 cycles -> START_SORT one cycle later; stable high for 4 cycles -> SORT_DONE plus done.
REQ-037 SHALL verify that cmd_from_root=START_SORT with alert_from_root=1 in WAIT_ACK keeps the FSM in WAIT_ACK, and a later SORT_ACK advances it.
REQ-038 SHALL verify that stable pattern 1,1,1,0,1,1,1,1 yields done exactly after the final 4 ones.
REQ-039 SHALL verify that rst asserted in SORTING gives IDLE and all outputs 0/NOP on the next cycle, and that start re-arms normally afterwards.
REQ-040 SHALL verify, with KD_ROOT_TIMEOUT_EN and TIMEOUT=16 and no ack, that error pulses at cycle 16 of WAIT_ACK, done never asserts, and the FSM returns to IDLE.
